// File: rtl/dcnt_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dcnt_pkg : shared state encoding and default sizes for the dcnt timer
// Revision : 1.0
// ---------------------------------------------------------------------------
package dcnt_pkg;

  localparam int DEF_WIDTH  = 3;
  localparam int DEF_PCNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dcnt_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dcnt_core : WIDTH-bit loadable down counter with terminal (==1) flag
// Revision  : 1.0
// ---------------------------------------------------------------------------
module dcnt_core
  import dcnt_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             is_one
);

  logic [WIDTH-1:0] cnt;

  // Decrement is guarded at zero so the counter can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign count  = cnt;
  assign is_one = (cnt == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/dcnt_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dcnt_ctrl : config, FSM, period counter and pulse generation for dcnt_core
// Revision  : 1.0
// ---------------------------------------------------------------------------
module dcnt_ctrl
  import dcnt_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int PCNT_W = DEF_PCNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WIDTH-1:0]  cfg_reload,
  input  logic              cfg_periodic,
  input  logic              start,
  input  logic              hold,
  input  logic              stop,
  output logic [WIDTH-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              abort,
  output logic [PCNT_W-1:0] period_cnt
);

  state_t           state, next_state;
  logic [WIDTH-1:0] reload_reg;
  logic             periodic_reg;

  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             dec;
  logic             is_one;
  logic             done_nxt;
  logic             abort_nxt;
  logic             pc_clr;
  logic             pc_inc;

  dcnt_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst_n    (rst),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .count    (count),
    .is_one   (is_one)
  );

  assign cfg_ready = (state == ST_IDLE);
  assign busy      = (state == ST_RUN) || (state == ST_HOLD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_val   = reload_reg;
    dec        = 1'b0;
    done_nxt   = 1'b0;
    abort_nxt  = 1'b0;
    pc_clr     = 1'b0;
    pc_inc     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          if (reload_reg != '0) begin
            load       = 1'b1;
            pc_clr     = 1'b1;
            next_state = ST_RUN;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          load       = 1'b1;
          load_val   = '0;
          abort_nxt  = 1'b1;
          next_state = ST_IDLE;
        end else if (hold) begin
          next_state = ST_HOLD;
        end else if (count == '0) begin
          // Only reachable in periodic mode: the cycle after terminal reloads.
          load = 1'b1;
          if (!periodic_reg) begin
            next_state = ST_IDLE;
          end
        end else if (is_one) begin
          dec      = 1'b1;
          done_nxt = 1'b1;
          pc_inc   = 1'b1;
          if (!periodic_reg) begin
            next_state = ST_IDLE;
          end
        end else begin
          dec = 1'b1;
        end
      end
      ST_HOLD: begin
        if (stop) begin
          load       = 1'b1;
          load_val   = '0;
          abort_nxt  = 1'b1;
          next_state = ST_IDLE;
        end else if (!hold) begin
          next_state = ST_RUN;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reload_reg   <= '0;
      periodic_reg <= 1'b0;
    end else if (cfg_valid && cfg_ready) begin
      reload_reg   <= cfg_reload;
      periodic_reg <= cfg_periodic;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done       <= 1'b0;
      abort      <= 1'b0;
      period_cnt <= '0;
    end else begin
      done  <= done_nxt;
      abort <= abort_nxt;
      if (pc_clr) begin
        period_cnt <= '0;
      end else if (pc_inc && (period_cnt != {PCNT_W{1'b1}})) begin
        period_cnt <= period_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcnt_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dcnt_ctrl : directed self-checking bench for dcnt_ctrl
// Revision     : 1.0
// ---------------------------------------------------------------------------
module tb_dcnt_ctrl;

  localparam int WIDTH  = 3;
  localparam int PCNT_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [WIDTH-1:0]  cfg_reload;
  logic              cfg_periodic;
  logic              start;
  logic              hold;
  logic              stop;
  logic [WIDTH-1:0]  count;
  logic              busy;
  logic              done;
  logic              abort;
  logic [PCNT_W-1:0] period_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dcnt_ctrl #(.WIDTH(WIDTH), .PCNT_W(PCNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_reload   (cfg_reload),
    .cfg_periodic (cfg_periodic),
    .start        (start),
    .hold         (hold),
    .stop         (stop),
    .count        (count),
    .busy         (busy),
    .done         (done),
    .abort        (abort),
    .period_cnt   (period_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [WIDTH-1:0] rl, input logic per);
    cfg_valid    = 1'b1;
    cfg_reload   = rl;
    cfg_periodic = per;
    tick();
    cfg_valid    = 1'b0;
  endtask

  task automatic kick;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b0; cfg_valid = 1'b0; cfg_reload = '0; cfg_periodic = 1'b0;
    start = 1'b0; hold = 1'b0; stop = 1'b0;
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_abort", 32'(abort), 0);
    chk("rst_cfg_ready", 32'(cfg_ready), 1);
    chk("rst_pcnt", 32'(period_cnt), 0);
    rst = 1'b1;
    tick();

    // one-shot, reload 5
    cfg(3'd5, 1'b0);
    kick();
    chk("os_load", 32'(count), 5);
    chk("os_busy", 32'(busy), 1);
    chk("os_pcnt0", 32'(period_cnt), 0);
    for (int i = 4; i >= 1; i--) begin
      tick();
      chk("os_count", 32'(count), 32'(i));
      chk("os_nodone", 32'(done), 0);
    end
    tick();
    chk("os_term_count", 32'(count), 0);
    chk("os_term_done", 32'(done), 1);
    chk("os_term_busy", 32'(busy), 0);
    chk("os_term_pcnt", 32'(period_cnt), 1);
    chk("os_term_ready", 32'(cfg_ready), 1);
    tick();
    chk("os_idle_count", 32'(count), 0);
    chk("os_idle_done", 32'(done), 0);

    // periodic, reload 2; config attempt mid-run must be refused
    cfg(3'd2, 1'b1);
    kick();
    chk("per_load", 32'(count), 2);
    tick();
    chk("per_1", 32'(count), 1);
    tick();
    chk("per_0", 32'(count), 0);
    chk("per_done1", 32'(done), 1);
    chk("per_pcnt1", 32'(period_cnt), 1);
    chk("per_busy", 32'(busy), 1);
    cfg_valid = 1'b1; cfg_reload = 3'd5; cfg_periodic = 1'b0;
    chk("per_cfg_ready", 32'(cfg_ready), 0);
    tick();
    cfg_valid = 1'b0;
    chk("per_reload", 32'(count), 2);
    chk("per_done_off", 32'(done), 0);
    tick();
    chk("per_1b", 32'(count), 1);
    tick();
    chk("per_0b", 32'(count), 0);
    chk("per_done2", 32'(done), 1);
    chk("per_pcnt2", 32'(period_cnt), 2);
    tick();
    chk("per_reload2", 32'(count), 2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("per_stop_count", 32'(count), 0);
    chk("per_stop_abort", 32'(abort), 1);
    chk("per_stop_done", 32'(done), 0);
    chk("per_stop_busy", 32'(busy), 0);
    tick();
    chk("per_abort_off", 32'(abort), 0);
    kick();
    chk("per_reload_kept", 32'(count), 2);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // hold then stop, reload 7
    cfg(3'd7, 1'b0);
    kick();
    tick(); tick(); tick();
    chk("hs_pre", 32'(count), 4);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hs_frozen", 32'(count), 4);
      chk("hs_busy", 32'(busy), 1);
    end
    hold = 1'b0;
    tick();
    chk("hs_resume_edge", 32'(count), 4);
    tick();
    chk("hs_first_dec", 32'(count), 3);
    tick();
    chk("hs_2", 32'(count), 2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("hs_stop_count", 32'(count), 0);
    chk("hs_stop_abort", 32'(abort), 1);
    chk("hs_stop_done", 32'(done), 0);
    chk("hs_stop_busy", 32'(busy), 0);
    tick();
    chk("hs_abort_off", 32'(abort), 0);
    chk("hs_idle_done", 32'(done), 0);

    // zero reload: done pulse, never busy
    cfg(3'd0, 1'b0);
    kick();
    chk("z_done", 32'(done), 1);
    chk("z_busy", 32'(busy), 0);
    chk("z_count", 32'(count), 0);
    tick();
    chk("z_done_off", 32'(done), 0);
    chk("z_busy2", 32'(busy), 0);

    // start+stop together in IDLE: nothing happens
    cfg(3'd3, 1'b0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", 32'(busy), 0);
    chk("ss_count", 32'(count), 0);
    chk("ss_done", 32'(done), 0);
    chk("ss_abort", 32'(abort), 0);

    // stop beats hold in RUN
    kick();
    chk("pr_load", 32'(count), 3);
    stop = 1'b1; hold = 1'b1;
    tick();
    stop = 1'b0; hold = 1'b0;
    chk("pr_abort", 32'(abort), 1);
    chk("pr_busy", 32'(busy), 0);
    chk("pr_count", 32'(count), 0);

    // config and start on the same edge: start uses old reload
    cfg_valid = 1'b1; cfg_reload = 3'd6; cfg_periodic = 1'b0; start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    chk("cs_old_reload", 32'(count), 3);
    chk("cs_busy", 32'(busy), 1);
    tick(); tick(); tick();
    chk("cs_done", 32'(done), 1);
    tick();
    kick();
    chk("cs_new_reload", 32'(count), 6);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // asynchronous reset mid-run
    cfg(3'd3, 1'b0);
    kick();
    chk("ar_pre", 32'(count), 3);
    #2 rst = 1'b0;
    #1;
    chk("ar_count", 32'(count), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_done", 32'(done), 0);
    chk("ar_ready", 32'(cfg_ready), 1);
    #2 rst = 1'b1;
    tick();
    chk("ar_idle", 32'(busy), 0);
    cfg(3'd3, 1'b0);
    kick();
    chk("ar_restart", 32'(count), 3);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // period counter saturation: reload 1 periodic, period 2 cycles
    cfg(3'd1, 1'b1);
    kick();
    for (int i = 0; i < 530; i++) tick();
    chk("sat_pcnt", 32'(period_cnt), 255);
    chk("sat_busy", 32'(busy), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("sat_stop", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
